memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port round-robin arbiter and sequencer placed in front of `memory_unit`. It lets the CPU instruction-fetch path (port 0) and the data-access path (port 1) share the single memory port. Each access runs to completion through a fixed state sequence that drives `rw_flag`, `address` and `write_memory_value`, and captures `read_memory_value`. One transaction is in flight at a time. Completion is signalled to the winning requester with a one-cycle `done` pulse.

## Interface

Parameters:
- `W`, default 8: width of `DEFAULT_TYPE` data and address words.

Ports:
- `CLOCK`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request, port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read; sampled with the request.
- `addr0` / `addr1`  in  W  access address.
- `wdata0` / `wdata1`  in  W  write data.
- `done0` / `done1`  out  1  one-cycle completion pulse to the granted port.
- `rdata`  out  W  read result; valid while a `done` for a read is high, held otherwise.
- `busy`  out  1  high in every state except IDLE.
- `rw_flag`  out  `MEMORY_FLAG_TYPE`  to `memory_unit`; `MEMORY_WRITE` only in ACCESS of a write, `MEMORY_READ` otherwise.
- `address`  out  W  to `memory_unit`.
- `write_memory_value`  out  W  to `memory_unit`.
- `read_memory_value`  in  W  from `memory_unit`; registered there, valid the cycle after the address is presented.

## Operation

- States: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - If no request: stay in IDLE, hold the memory outputs.
  - If any `req` is high: select a winner, latch its `we`, `addr` and `wdata` into registers, record it as `last`, and go to ACCESS.
- **Arbitration**
  - One requester: it wins.
  - Both requesting: the port that is not `last` wins.
  - `last` resets to 1, so port 0 wins the first contested cycle.
- **ACCESS**
  - `address` and `write_memory_value` come from the latched registers.
  - `rw_flag` is `MEMORY_WRITE` for a write, `MEMORY_READ` for a read.
  - Next state: write → DONE; read → WAIT.
- **WAIT** (read only)
  - `rw_flag` is `MEMORY_READ`; the address is held.
  - `read_memory_value` is registered into `rdata` at the end of the cycle; go to DONE.
- **DONE**
  - The `done` of the winner is high for exactly this cycle; the other `done` stays 0.
  - Memory outputs are held, `rw_flag` is `MEMORY_READ`; go to IDLE.
- **Request inputs**
  - They are sampled only in IDLE; changes in other states are ignored.
  - The requester deasserts `req` no later than the cycle after its `done`. A `req` still high in IDLE is a new request.
- `done0` and `done1` are never high together.

## Timing

- Cycle numbering: request first sampled in IDLE at cycle 0.
- Write:
  - ACCESS at cycle 1; memory commits on the edge ending cycle 1.
  - `done` at cycle 2; IDLE at cycle 3.
  - Request-to-request throughput: 3 cycles.
- Read:
  - ACCESS at cycle 1, WAIT at cycle 2.
  - `done` with valid `rdata` at cycle 3; IDLE at cycle 4.
  - Throughput: 4 cycles.
- Reset values:
  - State IDLE, `last` = 1.
  - `done0` = `done1` = 0, `busy` = 0.
  - `rdata` = 0, `address` = 0, `write_memory_value` = 0, `rw_flag` = `MEMORY_READ`.
- RESET in any state:
  - Next state IDLE, with all reset values applied; no `done` is issued for the aborted transaction.
  - For a write aborted in ACCESS, the commit is governed by `memory_unit`'s own reset on the same `RESET`; no completion is reported.
- A request raised during the DONE cycle is first seen in the following IDLE cycle.
- Continuous requests on both ports alternate grants 0, 1, 0, 1, …; neither port is starved.
- Address and data are used exactly as W-bit values; there is no arithmetic and no wrap handling in the block.

## Test plan

- Reset, then port 0 reads `addr0` = 8'h10 while memory holds 8'hA5 → `done0` = 1 at cycle 3, `rdata` = 8'hA5, `busy` high in cycles 1–3 (cycles counted from the IDLE sample), `done1` = 0.
- Port 1 writes 8'h3C to 8'h20, then port 0 reads 8'h20 → `rw_flag` = `MEMORY_WRITE` only in the write's ACCESS cycle, `done1` at cycle 2, subsequent read returns 8'h3C.
- Both ports request reads simultaneously after reset → port 0 completes first (`done0`), port 1 immediately after (`done1` 4 cycles later); pattern repeats 0, 1 over 4 rounds.
- Port 1 holds `req1` continuously while port 0 requests once mid-stream → port 0 is granted at the next IDLE; port 1 is delayed by exactly one transaction.
- RESET asserted during WAIT of a read → next cycle IDLE, all outputs at reset values, no `done` pulse, and a following read completes normally.
- `addr0` and `we0` changed during ACCESS → memory still sees the values latched in IDLE.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters, the memory_arbiter and memory_unit.
// The slave modport is the arbiter's view. The master modport is the view of
// everything around the arbiter: both requesters and the memory.
interface memory_arbiter_if #(
    parameter int W = 8
);
    // requester side
    logic         req0;
    logic         req1;
    logic         we0;
    logic         we1;
    logic [W-1:0] addr0;
    logic [W-1:0] addr1;
    logic [W-1:0] wdata0;
    logic [W-1:0] wdata1;
    logic         done0;
    logic         done1;
    logic [W-1:0] rdata;
    logic         busy;

    // memory_unit side
    logic         rw_flag;
    logic [W-1:0] address;
    logic [W-1:0] write_memory_value;
    logic [W-1:0] read_memory_value;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  read_memory_value,
        output done0, done1, rdata, busy,
        output rw_flag, address, write_memory_value
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output read_memory_value,
        input  done0, done1, rdata, busy,
        input  rw_flag, address, write_memory_value
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of memory_unit.
// Port 0 is instruction fetch and port 1 is data access. Only one transaction
// is in flight at a time. Each transaction runs IDLE -> ACCESS -> (WAIT) -> DONE.
module memory_arbiter #(
    parameter int W = 8
) (
    input  logic            CLOCK,
    input  logic            RESET,
    memory_arbiter_if.slave bus
);
    // memory_unit flag encoding
    localparam logic MEMORY_READ  = 1'b0;
    localparam logic MEMORY_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic         r_last;   // port granted most recently
    logic         r_sel;    // port owning the current transaction
    logic         r_we;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic [W-1:0] r_rdata;

    logic         w_any_req;
    logic         w_grant;

    assign w_any_req = bus.req0 | bus.req1;
    // A lone requester always wins. When both ports request, the port that
    // was not served last wins, which makes continuous requests alternate.
    assign w_grant   = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

    // State register
    // NOTE: sequential state is always written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: writes skip WAIT because the memory commits on the ACCESS edge
    // NOTE: the default assignment at the top of a combinational block prevents latch inference.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = r_we ? S_DONE : S_WAIT;
            S_WAIT:   w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Request latch in IDLE, and read-data capture at the end of WAIT
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_sel   <= w_grant;
                r_last  <= w_grant;
                r_we    <= w_grant ? bus.we1    : bus.we0;
                r_addr  <= w_grant ? bus.addr1  : bus.addr0;
                r_wdata <= w_grant ? bus.wdata1 : bus.wdata0;
            end
            if (r_state == S_WAIT) begin
                r_rdata <= bus.read_memory_value;
            end
        end
    end

    // Output decode: memory outputs come from the latched request and hold between transactions
    always_comb begin
        bus.busy               = (r_state != S_IDLE);
        bus.done0              = (r_state == S_DONE) && !r_sel;
        bus.done1              = (r_state == S_DONE) &&  r_sel;
        bus.rw_flag            = (r_state == S_ACCESS && r_we) ? MEMORY_WRITE : MEMORY_READ;
        bus.address            = r_addr;
        bus.write_memory_value = r_wdata;
        bus.rdata              = r_rdata;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter. A directed vector table covers the
// basic read and write flows, and hand sequences cover contention and starvation.
// Randomized traffic is checked every cycle against a transaction-level model.
module tb_memory_arbiter;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic clk;
    logic rst;

    memory_arbiter_if #(.W(8)) bus ();

    memory_arbiter #(.W(8)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] a;
        a = 8'(i);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    // memory_unit stand-in: registered read, write committed on the edge when rw_flag = write
    logic [7:0] mem [256];
    bit         mem_init = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
                mem_init <= 1;
            end
        end else begin
            bus.read_memory_value <= mem[bus.address];
            if (bus.rw_flag == WR) mem[bus.address] <= bus.write_memory_value;
        end
    end

    // Transaction-level reference model. m_phase is the number of cycles since
    // the request was accepted (0 = idle). A write lasts 2 cycles and a read 3.
    // The memory array is updated at the moments the timing rules state.
    bit         m_valid = 0;
    int         m_phase;
    logic       m_owner, m_we, m_last;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (rst) begin
            if (!m_valid) begin
                for (int i = 0; i < 256; i++) ref_mem[i] <= init_val(i);
            end
            m_valid <= 1;
            m_phase <= 0;
            m_last  <= 1'b1;
            m_owner <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 8'h00;
            m_wdata <= 8'h00;
            m_rdata <= 8'h00;
        end else if (m_valid) begin
            if (m_phase == 0) begin
                if (bus.req0 || bus.req1) begin
                    logic win;
                    if (bus.req0 && !bus.req1)      win = 1'b0;
                    else if (bus.req1 && !bus.req0) win = 1'b1;
                    else                            win = (m_last == 1'b1) ? 1'b0 : 1'b1;
                    m_owner <= win;
                    m_last  <= win;
                    m_we    <= win ? bus.we1 : bus.we0;
                    m_addr  <= win ? bus.addr1 : bus.addr0;
                    m_wdata <= win ? bus.wdata1 : bus.wdata0;
                    m_phase <= 1;
                end
            end else if (m_phase == (m_we ? 2 : 3)) begin
                m_phase <= 0;
            end else begin
                if (m_phase == 1 && m_we)  ref_mem[m_addr] <= m_wdata;
                if (m_phase == 2 && !m_we) m_rdata <= ref_mem[m_addr];
                m_phase <= m_phase + 1;
            end
        end
    end

    // Model comparison, sampled mid-cycle
    always @(negedge clk) begin
        if (m_valid) begin
            int len;
            len = m_we ? 2 : 3;
            check("model_busy",  bus.busy,  (m_phase != 0));
            check("model_done0", bus.done0, (m_phase == len && m_owner == 1'b0));
            check("model_done1", bus.done1, (m_phase == len && m_owner == 1'b1));
            check("model_rw",    bus.rw_flag, (m_phase == 1 && m_we) ? WR : RD);
            check("model_addr",  bus.address, m_addr);
            check("model_wmv",   bus.write_memory_value, m_wdata);
            check("model_rdata", bus.rdata, m_rdata);
        end
    end

    typedef struct {
        logic       rst;
        logic       req0;
        logic       we0;
        logic [7:0] addr0;
        logic [7:0] wdata0;
        logic       req1;
        logic       we1;
        logic [7:0] addr1;
        logic [7:0] wdata1;
        logic       busy;
        logic       done0;
        logic       done1;
        logic       rw;
        logic [7:0] rdata;
        logic [7:0] address;
        logic [7:0] wmv;
    } vec_t;

    vec_t vec [20];

    task automatic drive_idle();
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        //          rst r0 w0 a0     d0     r1 w1 a1     d1     bsy d0 d1 rw  rdata  addr   wmv
        vec[0]  = '{0, 1, RD, 8'h10, 8'h00, 0, RD, 8'h00, 8'h00, 0, 0, 0, RD, 8'h00, 8'h00, 8'h00};
        vec[1]  = '{0, 1, WR, 8'h55, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 0, RD, 8'h00, 8'h10, 8'h00};
        vec[2]  = '{0, 1, WR, 8'h55, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 0, RD, 8'h00, 8'h10, 8'h00};
        vec[3]  = '{0, 0, RD, 8'h00, 8'h00, 0, RD, 8'h00, 8'h00, 1, 1, 0, RD, 8'hA5, 8'h10, 8'h00};
        vec[4]  = '{0, 0, RD, 8'h00, 8'h00, 1, WR, 8'h20, 8'h3C, 0, 0, 0, RD, 8'hA5, 8'h10, 8'h00};
        vec[5]  = '{0, 0, RD, 8'h00, 8'h00, 1, WR, 8'h20, 8'h3C, 1, 0, 0, WR, 8'hA5, 8'h20, 8'h3C};
        vec[6]  = '{0, 1, RD, 8'h20, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 1, RD, 8'hA5, 8'h20, 8'h3C};
        vec[7]  = '{0, 1, RD, 8'h20, 8'h00, 0, RD, 8'h00, 8'h00, 0, 0, 0, RD, 8'hA5, 8'h20, 8'h3C};
        vec[8]  = '{0, 1, RD, 8'h20, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 0, RD, 8'hA5, 8'h20, 8'h00};
        vec[9]  = '{0, 1, RD, 8'h20, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 0, RD, 8'hA5, 8'h20, 8'h00};
        vec[10] = '{0, 0, RD, 8'h00, 8'h00, 0, RD, 8'h00, 8'h00, 1, 1, 0, RD, 8'h3C, 8'h20, 8'h00};
        vec[11] = '{0, 0, RD, 8'h00, 8'h00, 0, RD, 8'h00, 8'h00, 0, 0, 0, RD, 8'h3C, 8'h20, 8'h00};
        vec[12] = '{0, 0, RD, 8'h00, 8'h00, 1, RD, 8'h10, 8'h00, 0, 0, 0, RD, 8'h3C, 8'h20, 8'h00};
        vec[13] = '{0, 0, RD, 8'h00, 8'h00, 1, RD, 8'h10, 8'h00, 1, 0, 0, RD, 8'h3C, 8'h10, 8'h00};
        vec[14] = '{1, 0, RD, 8'h00, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 0, RD, 8'h3C, 8'h10, 8'h00};
        vec[15] = '{0, 0, RD, 8'h00, 8'h00, 0, RD, 8'h00, 8'h00, 0, 0, 0, RD, 8'h00, 8'h00, 8'h00};
        vec[16] = '{0, 1, RD, 8'h10, 8'h00, 0, RD, 8'h00, 8'h00, 0, 0, 0, RD, 8'h00, 8'h00, 8'h00};
        vec[17] = '{0, 1, RD, 8'h10, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 0, RD, 8'h00, 8'h10, 8'h00};
        vec[18] = '{0, 0, RD, 8'h00, 8'h00, 0, RD, 8'h00, 8'h00, 1, 0, 0, RD, 8'h00, 8'h10, 8'h00};
        vec[19] = '{0, 0, RD, 8'h00, 8'h00, 0, RD, 8'h00, 8'h00, 1, 1, 0, RD, 8'hA5, 8'h10, 8'h00};

        do_reset();

        // Directed vectors: read, write then read-back, reset in WAIT, recovery
        for (int i = 0; i < 20; i++) begin
            rst        = vec[i].rst;
            bus.req0   = vec[i].req0;  bus.we0 = vec[i].we0;
            bus.addr0  = vec[i].addr0; bus.wdata0 = vec[i].wdata0;
            bus.req1   = vec[i].req1;  bus.we1 = vec[i].we1;
            bus.addr1  = vec[i].addr1; bus.wdata1 = vec[i].wdata1;
            @(negedge clk);
            check($sformatf("vec%0d_busy", i),  bus.busy,  vec[i].busy);
            check($sformatf("vec%0d_done0", i), bus.done0, vec[i].done0);
            check($sformatf("vec%0d_done1", i), bus.done1, vec[i].done1);
            check($sformatf("vec%0d_rw", i),    bus.rw_flag, vec[i].rw);
            check($sformatf("vec%0d_rdata", i), bus.rdata, vec[i].rdata);
            check($sformatf("vec%0d_addr", i),  bus.address, vec[i].address);
            check($sformatf("vec%0d_wmv", i),   bus.write_memory_value, vec[i].wmv);
            next_cycle();
        end
        rst = 1'b0;

        // Both ports issue reads continuously: grants alternate 0,1,0,1
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus.req0 = 1; bus.we0 = RD; bus.addr0 = 8'(c);
            bus.req1 = 1; bus.we1 = RD; bus.addr1 = 8'(c + 32);
            @(negedge clk);
            check($sformatf("rr_c%0d_done0", c), bus.done0, (c == 3 || c == 11));
            check($sformatf("rr_c%0d_done1", c), bus.done1, (c == 7 || c == 15));
            next_cycle();
        end

        // Port 1 streams reads; port 0 requests once mid-stream and is served next
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bus.req1 = 1; bus.we1 = RD; bus.addr1 = 8'h40;
            bus.req0 = (c >= 2 && c <= 7); bus.we0 = RD; bus.addr0 = 8'h41;
            @(negedge clk);
            check($sformatf("st_c%0d_done0", c), bus.done0, (c == 7));
            check($sformatf("st_c%0d_done1", c), bus.done1, (c == 3 || c == 11));
            next_cycle();
        end

        // Randomized traffic with occasional resets, checked by the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            bus.req0   = 1'($urandom_range(0, 1));
            bus.we0    = 1'($urandom_range(0, 1));
            bus.addr0  = 8'($urandom_range(0, 15));
            bus.wdata0 = 8'($urandom);
            bus.req1   = 1'($urandom_range(0, 1));
            bus.we1    = 1'($urandom_range(0, 1));
            bus.addr1  = 8'($urandom_range(0, 15));
            bus.wdata1 = 8'($urandom);
            next_cycle();
        end
        rst = 1'b0;
        drive_idle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
